// File: rtl/mat_operand_streamer.sv
// rtl/mat_operand_streamer.sv - X/Y operand store, row/column streamer and result capture for mat_mult
// Streams 16 operand pairs, captures LAT-delayed AB results, then pulses done.
module mat_operand_streamer #(
  parameter int LAT = 1,
  parameter int AW  = 9,
  parameter int BW  = 8,
  parameter int RW  = 11
) (
  input  logic          clk_80,
  input  logic          rst_n_80,
  input  logic          wr_en_80,
  input  logic          wr_sel_80,
  input  logic [3:0]    wr_addr_80,
  input  logic [AW-1:0] wr_data_80,
  input  logic          start_80,
  output logic          busy_80,
  output logic          done_80,
  output logic [AW-1:0] A00_80,
  output logic [AW-1:0] A01_80,
  output logic [AW-1:0] A02_80,
  output logic [AW-1:0] A03_80,
  output logic [BW-1:0] B00_80,
  output logic [BW-1:0] B01_80,
  output logic [BW-1:0] B02_80,
  output logic [BW-1:0] B03_80,
  output logic          op_valid_80,
  input  logic [RW-1:0] AB00_80,
  input  logic [3:0]    rd_addr_80,
  output logic [RW-1:0] rd_data_80
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t        state_q;
  logic [3:0]    t_q;
  logic [3:0]    op_t_q;
  logic          op_valid_q;
  logic          busy_q;
  logic          done_q;
  logic [AW-1:0] x_q   [16];
  logic [BW-1:0] y_q   [16];
  logic [RW-1:0] res_q [16];
  logic [AW-1:0] a_q   [4];
  logic [BW-1:0] b_q   [4];
  logic          vld_q [LAT];
  logic [3:0]    idx_q [LAT];

  always_ff @(posedge clk_80 or negedge rst_n_80) begin
    if (!rst_n_80) begin
      state_q    <= IDLE;
      t_q        <= '0;
      op_t_q     <= '0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        res_q[i] <= '0;
      end
      for (int k = 0; k < 4; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int i = 0; i < LAT; i++) begin
        vld_q[i] <= 1'b0;
        idx_q[i] <= '0;
      end
    end else begin
      // Delay line aligns each presented pair index with its returning result
      for (int i = LAT - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
      vld_q[0] <= op_valid_q;
      idx_q[0] <= op_t_q;
      if (vld_q[LAT-1]) begin
        res_q[idx_q[LAT-1]] <= AB00_80;
      end
      done_q <= 1'b0;

      case (state_q)
        IDLE, DONE: begin
          if (wr_en_80) begin
            if (wr_sel_80) y_q[wr_addr_80] <= wr_data_80[BW-1:0];
            else           x_q[wr_addr_80] <= wr_data_80;
          end
          if (start_80) begin
            state_q <= STREAM;
            busy_q  <= 1'b1;
            t_q     <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        STREAM: begin
          for (int k = 0; k < 4; k++) begin
            a_q[k] <= x_q[{t_q[3:2], 2'(k)}];
            b_q[k] <= y_q[{2'(k), t_q[1:0]}];
          end
          op_valid_q <= 1'b1;
          op_t_q     <= t_q;
          t_q        <= t_q + 4'd1;
          if (t_q == 4'hF) state_q <= DRAIN;
        end
        DRAIN: begin
          op_valid_q <= 1'b0;
          if (vld_q[LAT-1] && idx_q[LAT-1] == 4'hF) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_80     = busy_q;
  assign done_80     = done_q;
  assign op_valid_80 = op_valid_q;
  assign A00_80      = a_q[0];
  assign A01_80      = a_q[1];
  assign A02_80      = a_q[2];
  assign A03_80      = a_q[3];
  assign B00_80      = b_q[0];
  assign B01_80      = b_q[1];
  assign B02_80      = b_q[2];
  assign B03_80      = b_q[3];
  assign rd_data_80  = res_q[rd_addr_80];

endmodule

// File: tb/tb_mat_operand_streamer.sv
// tb/tb_mat_operand_streamer.sv - scoreboard bench for mat_operand_streamer at LAT=1 and LAT=3
module tb_mat_operand_streamer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic       wr_sel = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [8:0] wr_data = '0;
  logic       start = 1'b0;
  logic [3:0] rd_addr = '0;

  logic        busy1, done1, opv1, busy3, done3, opv3;
  logic [8:0]  a1 [4];
  logic [8:0]  a3 [4];
  logic [7:0]  b1 [4];
  logic [7:0]  b3 [4];
  logic [10:0] ab1, ab3, rd1, rd3;

  always #5 clk = ~clk;

  mat_operand_streamer #(.LAT(1)) dut1 (
    .clk_80(clk), .rst_n_80(rst_n), .wr_en_80(wr_en), .wr_sel_80(wr_sel),
    .wr_addr_80(wr_addr), .wr_data_80(wr_data), .start_80(start),
    .busy_80(busy1), .done_80(done1),
    .A00_80(a1[0]), .A01_80(a1[1]), .A02_80(a1[2]), .A03_80(a1[3]),
    .B00_80(b1[0]), .B01_80(b1[1]), .B02_80(b1[2]), .B03_80(b1[3]),
    .op_valid_80(opv1), .AB00_80(ab1), .rd_addr_80(rd_addr), .rd_data_80(rd1)
  );

  mat_operand_streamer #(.LAT(3)) dut3 (
    .clk_80(clk), .rst_n_80(rst_n), .wr_en_80(wr_en), .wr_sel_80(wr_sel),
    .wr_addr_80(wr_addr), .wr_data_80(wr_data), .start_80(start),
    .busy_80(busy3), .done_80(done3),
    .A00_80(a3[0]), .A01_80(a3[1]), .A02_80(a3[2]), .A03_80(a3[3]),
    .B00_80(b3[0]), .B01_80(b3[1]), .B02_80(b3[2]), .B03_80(b3[3]),
    .op_valid_80(opv3), .AB00_80(ab3), .rd_addr_80(rd_addr), .rd_data_80(rd3)
  );

  // mat_mult stand-ins: result for the n-th pair of a pass is 7*n+1, LAT clocks later
  logic [3:0]  cnt1, cnt3;
  logic [10:0] pipe1;
  logic [10:0] pipe3 [3];
  assign ab1 = pipe1;
  assign ab3 = pipe3[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1 <= '0; cnt3 <= '0; pipe1 <= '0;
      pipe3[0] <= '0; pipe3[1] <= '0; pipe3[2] <= '0;
    end else begin
      pipe1    <= opv1 ? 11'(7 * cnt1 + 1) : 11'd0;
      cnt1     <= opv1 ? cnt1 + 4'd1 : cnt1;
      pipe3[0] <= opv3 ? 11'(7 * cnt3 + 1) : 11'd0;
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
      cnt3     <= opv3 ? cnt3 + 4'd1 : cnt3;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic [8:0]  xm [16];
  logic [7:0]  ym [16];
  logic [67:0] sb_q [$];
  int ndone1 = 0, ndone3 = 0, done_cyc1 = 0, done_cyc3 = 0;
  int nvalid1 = 0, nrise1 = 0, rise_cyc1 = 0;
  logic prev_v1 = 1'b0;

  always @(negedge clk) begin
    if (done1) begin ndone1++; done_cyc1 = cyc; end
    if (done3) begin ndone3++; done_cyc3 = cyc; end
    if (opv1) begin
      nvalid1++;
      if (!prev_v1) begin nrise1++; rise_cyc1 = cyc; end
      if (sb_q.size() == 0) check("op_extra", 1, 0);
      else check("op_pair", {a1[0], a1[1], a1[2], a1[3], b1[0], b1[1], b1[2], b1[3]}, sb_q.pop_front());
    end
    prev_v1 = opv1;
  end

  task automatic push_pass();
    for (int t = 0; t < 16; t++) begin
      int r = t / 4;
      int c = t % 4;
      sb_q.push_back({xm[r*4], xm[r*4+1], xm[r*4+2], xm[r*4+3],
                      ym[c], ym[4+c], ym[8+c], ym[12+c]});
    end
  endtask

  task automatic wr(input logic sel, input int addr, input int data);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr); wr_data = 9'(data);
    if (sel) ym[addr] = 8'(data); else xm[addr] = 9'(data);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int p1, input int p3);
    for (int i = 0; i < 80; i++) begin
      if (ndone1 > p1 && ndone3 > p3) break;
      @(negedge clk);
    end
    check("done_seen", {ndone1 > p1, ndone3 > p3}, 2'b11);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ctl"}, {busy1, done1, opv1, busy3, done3, opv3}, 0);
    check({tag, "_ab1"}, {a1[0], a1[1], a1[2], a1[3], b1[0], b1[1], b1[2], b1[3]}, 0);
    check({tag, "_ab3"}, {a3[0], a3[1], a3[2], a3[3], b3[0], b3[1], b3[2], b3[3]}, 0);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #0.1;
      check({tag, "_rd"}, {rd1, rd3}, 0);
    end
  endtask

  int ycol [4][4] = '{'{13, 77, 102, 205}, '{26, 166, 90, 38},
                      '{38, 154, 77, 230}, '{192, 115, 64, 13}};

  initial begin
    int s, p1, p3, v0, d, ri;
    for (int i = 0; i < 16; i++) begin xm[i] = '0; ym[i] = '0; end

    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) wr(1'b0, i, (i + 1) * 10);
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) wr(1'b1, k * 4 + c, ycol[c][k]);

    // First pass: stream contents, latency for both LAT values, result readback
    p1 = ndone1; p3 = ndone3; v0 = nvalid1;
    push_pass();
    @(negedge clk); start = 1'b1; s = cyc + 1;
    @(negedge clk); start = 1'b0;
    wait_done(p1, p3);
    check("lat1_done", done_cyc1 - s, 18);
    check("lat3_done", done_cyc3 - s, 20);
    check("valid_cycles", nvalid1 - v0, 16);
    check("sb_empty1", sb_q.size(), 0);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      check("result", {rd1, rd3}, {11'(7 * i + 1), 11'(7 * i + 1)});
    end

    // Writes and start during a pass must be ignored
    p1 = ndone1; p3 = ndone3;
    push_pass();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 9'd511; start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    wait_done(p1, p3);
    repeat (25) @(negedge clk);
    check("busy_done1", ndone1 - p1, 1);
    check("busy_done3", ndone3 - p3, 1);
    check("sb_empty2", sb_q.size(), 0);

    // Back-to-back with start held high; X[0] must still be the original value
    p1 = ndone1; p3 = ndone3;
    push_pass(); push_pass();
    @(negedge clk); start = 1'b1;
    for (int i = 0; i < 60 && ndone1 == p1; i++) @(negedge clk);
    d = done_cyc1; ri = nrise1;
    for (int i = 0; i < 10 && nrise1 == ri; i++) @(negedge clk);
    check("b2b_gap", rise_cyc1 - d, 2);
    for (int i = 0; i < 60 && ndone3 == p3; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done(p1 + 1, p3 + 1);
    check("sb_empty3", sb_q.size(), 0);

    // Abort at t=7, then a pass on cleared matrices with a write coincident with start
    push_pass();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    ri = nrise1;
    for (int i = 0; i < 10 && nrise1 == ri; i++) @(negedge clk);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("abort");
    sb_q.delete();
    for (int i = 0; i < 16; i++) begin xm[i] = '0; ym[i] = '0; end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    p1 = ndone1; p3 = ndone3;
    @(negedge clk);
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd5; wr_data = 9'd300; start = 1'b1;
    xm[5] = 9'd300;
    push_pass();
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    wait_done(p1, p3);
    check("sb_empty4", sb_q.size(), 0);
    rd_addr = 4'd15;
    #1;
    check("result_post", {rd1, rd3}, {11'd106, 11'd106});

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
